// File: rtl/dct_pkg.sv
// Shared types, width helpers and default Q-format constants for the 1-D
// transform engine.
package dct_pkg;

    localparam int unsigned DEF_N           = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_COEFF_WIDTH = 16;
    localparam int unsigned DEF_COEFF_FRAC  = 14;
    // Orthonormal DCT-II row-0 value in Q2.14: round(2^14 / sqrt(8)).
    localparam int unsigned DCT_ROW0_Q14    = 5793;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUT
    } state_e;

    function automatic int unsigned acc_width(input int unsigned dw,
                                              input int unsigned cw,
                                              input int unsigned n);
        return dw + cw + $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dct_1d_stream_if.sv
// Vector-in / vector-out handshake bundle of the 1-D transform engine.
interface dct_1d_stream_if
    import dct_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH
);
    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_WIDTH*N-1:0]        in_data;
    logic                           inverse;
    logic [COEFF_WIDTH*N*N-1:0]     coeff;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH*N-1:0]        out_data;
    logic                           out_sat;

    modport master (
        output in_valid, in_data, inverse, coeff, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, inverse, coeff, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/dct_mac_lane.sv
// One output lane: full-precision signed MAC plus round-half-up and
// saturation of the accumulated sum back to the sample width.
module dct_mac_lane #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned COEFF_FRAC  = 14,
    parameter int unsigned ACC_W       = 35
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr_i,
    input  logic                          en_i,
    input  logic signed [DATA_WIDTH-1:0]  x_i,
    input  logic signed [COEFF_WIDTH-1:0] c_i,
    output logic signed [DATA_WIDTH-1:0]  y_c_o,
    output logic                          sat_c_o
);
    localparam int unsigned PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam logic signed [ACC_W:0] ONE     = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] RND     = (COEFF_FRAC == 0) ? '0 : (ONE << (COEFF_FRAC - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ONE << (DATA_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W:0]    rnd_c, shr_c;

    assign prod_c = PROD_W'(x_i) * PROD_W'(c_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod_c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // One guard bit above ACC_W keeps the rounding add from wrapping.
    always_comb begin
        rnd_c   = (ACC_W+1)'(acc_q) + RND;
        shr_c   = rnd_c >>> COEFF_FRAC;
        y_c_o   = DATA_WIDTH'(shr_c);
        sat_c_o = 1'b0;
        if (shr_c > SAT_MAX) begin
            y_c_o   = DATA_WIDTH'(SAT_MAX);
            sat_c_o = 1'b1;
        end else if (shr_c < SAT_MIN) begin
            y_c_o   = DATA_WIDTH'(SAT_MIN);
            sat_c_o = 1'b1;
        end
    end
endmodule

// File: rtl/dct_1d_stream.sv
// N-point 1-D transform engine: y = C*x (forward) or y = C^T*x (inverse),
// one MAC lane per output stepping through the N input terms.
module dct_1d_stream
    import dct_pkg::*;
#(
    parameter int unsigned N           = DEF_N,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int unsigned COEFF_FRAC  = DEF_COEFF_FRAC
) (
    input  logic           clk,
    input  logic           reset,
    dct_1d_stream_if.slave bus
);
    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, COEFF_WIDTH, N);
    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              j_q, j_d;
    logic                          inv_q;
    logic signed [DATA_WIDTH-1:0]  x_q [N];
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH*N-1:0]       out_data_q;
    logic                          out_sat_q;

    logic                          accept_c, acc_clr_c, acc_en_c, capture_c;
    logic signed [DATA_WIDTH-1:0]  x_sel_c;
    logic signed [COEFF_WIDTH-1:0] c_arr [N][N];
    logic [DATA_WIDTH*N-1:0]       y_all_c;
    logic [N-1:0]                  sat_all_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        j_d         = j_q;
        out_valid_d = out_valid_q;
        accept_c    = 1'b0;
        acc_clr_c   = 1'b0;
        acc_en_c    = 1'b0;
        capture_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept_c  = 1'b1;
                    acc_clr_c = 1'b1;
                    j_d       = '0;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                acc_en_c = 1'b1;
                j_d      = j_q + CNT_W'(1);
                if (j_q == LAST) begin
                    j_d     = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                capture_c   = 1'b1;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j_q         <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int n = 0; n < N; n++) x_q[n] <= '0;
        end else begin
            j_q         <= j_d;
            out_valid_q <= out_valid_d;
            if (accept_c) begin
                inv_q <= bus.inverse;
                for (int n = 0; n < N; n++) x_q[n] <= bus.in_data[n*DATA_WIDTH +: DATA_WIDTH];
            end
            if (capture_c) begin
                out_data_q <= y_all_c;
                out_sat_q  <= |sat_all_c;
            end
        end
    end

    assign x_sel_c = x_q[j_q];

    // Lane k uses C[k][j] forward, C[j][k] inverse; coeff is deliberately not registered.
    for (genvar k = 0; k < N; k++) begin : g_lane
        for (genvar n = 0; n < N; n++) begin : g_coeff
            assign c_arr[k][n] = bus.coeff[(k*N+n)*COEFF_WIDTH +: COEFF_WIDTH];
        end

        logic signed [COEFF_WIDTH-1:0] c_sel_c;
        assign c_sel_c = inv_q ? c_arr[j_q][k] : c_arr[k][j_q];

        dct_mac_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .COEFF_WIDTH (COEFF_WIDTH),
            .COEFF_FRAC  (COEFF_FRAC),
            .ACC_W       (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (acc_clr_c),
            .en_i    (acc_en_c),
            .x_i     (x_sel_c),
            .c_i     (c_sel_c),
            .y_c_o   (y_all_c[k*DATA_WIDTH +: DATA_WIDTH]),
            .sat_c_o (sat_all_c[k])
        );
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_dct_1d_stream.sv
// Directed bench for dct_1d_stream: DCT-II, identity/transpose, rounding,
// saturation, initiation interval, backpressure and mid-operation reset.
module tb_dct_1d_stream;
    import dct_pkg::*;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cm [8][8];
    int   xv [8];
    time  t_acc;

    dct_1d_stream_if #(.N(8), .DATA_WIDTH(16), .COEFF_WIDTH(16)) bus ();

    dct_1d_stream #(.N(8), .DATA_WIDTH(16), .COEFF_WIDTH(16), .COEFF_FRAC(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lane(input int k);
        logic signed [15:0] v;
        v = bus.out_data[k*16 +: 16];
        return int'(v);
    endfunction

    // cos(m*pi/16) * 8192, by quadrant symmetry from the first-octant table.
    function automatic int dct_c(input int k, input int n);
        int t [9];
        int m;
        t = '{8192, 8035, 7568, 6811, 5793, 4551, 3135, 1598, 0};
        if (k == 0) return int'(DCT_ROW0_Q14);
        m = ((2*n + 1) * k) % 32;
        if (m <= 8)  return t[m];
        if (m <= 16) return -t[16-m];
        if (m <= 24) return -t[m-16];
        return t[32-m];
    endfunction

    task automatic load_coeff();
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++)
                bus.coeff[(k*8+n)*16 +: 16] = 16'(cm[k][n]);
    endtask

    task automatic clear_cm();
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) cm[k][n] = 0;
    endtask

    task automatic set_identity();
        clear_cm();
        for (int k = 0; k < 8; k++) cm[k][k] = 16384;
        load_coeff();
    endtask

    task automatic send_vec(input logic inv);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.inverse  = inv;
        for (int n = 0; n < 8; n++) bus.in_data[n*16 +: 16] = 16'(xv[n]);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, guard);
        end
        @(posedge clk);
        t_acc = $time;
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 50);
    endtask

    task automatic finish_out();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inverse   = 1'b0;
        bus.out_ready = 1'b1;
        bus.coeff     = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat: got %b want 0", bus.out_sat); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dct_forward();
        int lat;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) cm[k][n] = dct_c(k, n);
        load_coeff();
        for (int n = 0; n < 8; n++) xv[n] = 100;
        send_vec(1'b0);
        wait_out(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL dct_latency: got %0d want 9", lat); end
        checks++; if (lane(0) !== 283) begin errors++; $display("FAIL dct_y0: got %0d want 283", lane(0)); end
        for (int k = 1; k < 8; k++) begin
            checks++; if (lane(k) !== 0) begin errors++; $display("FAIL dct_y%0d: got %0d want 0", k, lane(k)); end
        end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL dct_sat: got %b want 0", bus.out_sat); end
        finish_out();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dct_hs_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL dct_hs_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_identity();
        int lat;
        xv = '{1, -2, 3, -4, 5, -6, 7, -8};
        set_identity();
        for (int m = 0; m < 2; m++) begin
            send_vec(m[0]);
            wait_out(lat);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (lane(k) !== xv[k]) begin errors++; $display("FAIL ident_inv%0d_y%0d: got %0d want %0d", m, k, lane(k), xv[k]); end
            end
            checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL ident_inv%0d_sat: got %b want 0", m, bus.out_sat); end
            finish_out();
        end
    endtask

    task automatic test_transpose();
        int lat;
        int fwd_exp [8];
        int inv_exp [8];
        fwd_exp = '{-1, 2, -2, 3, -3, 4, -4, -3};
        inv_exp = '{-7, 0, 0, 1, -1, 2, -2, 3};
        xv = '{1, -2, 3, -4, 5, -6, 7, -8};
        clear_cm();
        for (int k = 0; k < 8; k++) begin
            cm[k][(k+1)%8] = 16384;
            cm[k][k]       = 8192;
        end
        load_coeff();
        send_vec(1'b0);
        wait_out(lat);
        for (int k = 0; k < 8; k++) begin
            checks++; if (lane(k) !== fwd_exp[k]) begin errors++; $display("FAIL tr_fwd_y%0d: got %0d want %0d", k, lane(k), fwd_exp[k]); end
        end
        finish_out();
        send_vec(1'b1);
        wait_out(lat);
        for (int k = 0; k < 8; k++) begin
            checks++; if (lane(k) !== inv_exp[k]) begin errors++; $display("FAIL tr_inv_y%0d: got %0d want %0d", k, lane(k), inv_exp[k]); end
        end
        finish_out();
        clear_cm();
        for (int k = 0; k < 8; k++) begin
            cm[(k+1)%8][k] = 16384;
            cm[k][k]       = 8192;
        end
        load_coeff();
        send_vec(1'b0);
        wait_out(lat);
        for (int k = 0; k < 8; k++) begin
            checks++; if (lane(k) !== inv_exp[k]) begin errors++; $display("FAIL tr_fwdT_y%0d: got %0d want %0d", k, lane(k), inv_exp[k]); end
        end
        finish_out();
    endtask

    task automatic test_rounding();
        int lat;
        int xin [3];
        int yexp [3];
        xin  = '{8192, -8192, 24576};
        yexp = '{1, 0, 2};
        clear_cm();
        cm[0][0] = 1;
        load_coeff();
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) xv[n] = 0;
            xv[0] = xin[i];
            send_vec(1'b0);
            wait_out(lat);
            checks++; if (lane(0) !== yexp[i]) begin errors++; $display("FAIL round_%0d: got %0d want %0d", xin[i], lane(0), yexp[i]); end
            checks++; if (lane(1) !== 0) begin errors++; $display("FAIL round_%0d_y1: got %0d want 0", xin[i], lane(1)); end
            finish_out();
        end
    endtask

    task automatic test_saturation();
        int lat;
        int xin [3];
        int yexp [3];
        logic sexp [3];
        xin  = '{32767, -32768, 1};
        yexp = '{32767, -32768, 8};
        sexp = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) cm[k][n] = 16384;
        load_coeff();
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) xv[n] = xin[i];
            send_vec(1'b0);
            wait_out(lat);
            for (int k = 0; k < 8; k += 7) begin
                checks++; if (lane(k) !== yexp[i]) begin errors++; $display("FAIL sat_%0d_y%0d: got %0d want %0d", xin[i], k, lane(k), yexp[i]); end
            end
            checks++; if (bus.out_sat !== sexp[i]) begin errors++; $display("FAIL sat_%0d_flag: got %b want %b", xin[i], bus.out_sat, sexp[i]); end
            finish_out();
        end
    endtask

    task automatic test_back_to_back();
        int  lat;
        time t0;
        set_identity();
        xv = '{10, 20, 30, 40, 50, 60, 70, 80};
        send_vec(1'b0);
        t0 = t_acc;
        wait_out(lat);
        finish_out();
        xv = '{-5, -4, -3, -2, -1, 0, 1, 2};
        send_vec(1'b0);
        checks++; if ((t_acc - t0) / 10 !== 64'd11) begin errors++; $display("FAIL b2b_ii: got %0d want 11", (t_acc - t0) / 10); end
        wait_out(lat);
        checks++; if (lane(0) !== -5 || lane(7) !== 2) begin errors++; $display("FAIL b2b_data: got %0d,%0d want -5,2", lane(0), lane(7)); end
        finish_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] exp_pk;
        set_identity();
        xv = '{7, -7, 100, -100, 1000, -1000, 32000, -32000};
        for (int n = 0; n < 8; n++) exp_pk[n*16 +: 16] = 16'(xv[n]);
        bus.out_ready = 1'b0;
        send_vec(1'b0);
        wait_out(lat);
        bus.in_valid = 1'b1;
        bus.in_data  = '1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.out_data !== exp_pk) begin errors++; $display("FAIL bp_data_c%0d: got %h want %h", c, bus.out_data, exp_pk); end
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ctrl_c%0d: valid=%b ready=%b want 1,0", c, bus.out_valid, bus.in_ready); end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 0,1", bus.out_valid, bus.in_ready); end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_single_hs: valid=%b ready=%b want 0,1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_abort();
        int lat;
        set_identity();
        for (int n = 0; n < 8; n++) xv[n] = 30000;
        send_vec(1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got %b want 0", bus.out_valid); end
        xv = '{3, -3, 0, 9, -9, 1, -1, 2};
        send_vec(1'b1);
        wait_out(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL abort_latency: got %0d want 9", lat); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (lane(k) !== xv[k]) begin errors++; $display("FAIL abort_y%0d: got %0d want %0d", k, lane(k), xv[k]); end
        end
        finish_out();
    endtask

    initial begin
        test_reset();
        test_dct_forward();
        test_identity();
        test_transpose();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
